// File: rtl/microtile_sequencer_pkg.sv
// Shared definitions for the microtile sequencer.
//   tile_state_t : sequencer FSM states
//   NUM_TILES    : number of tiles sharing the I/O bus
//   TILE_W       : width of each tile's input and output bus
//   SEL_W        : width of a tile index
//   CNT_W        : width of the settle/reset down-counter
package microtile_sequencer_pkg;

  localparam int NUM_TILES = 4;
  localparam int TILE_W    = 8;
  localparam int SEL_W     = $clog2(NUM_TILES);
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_RUN     = 2'd2
  } tile_state_t;

endpackage

// File: rtl/microtile_sequencer_sync2.sv
// Two-flop synchronizer for asynchronous pin inputs.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (second flop)
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/microtile_sequencer.sv
// Owns one of four tiles on a shared I/O bus. A tile switch freezes the
// outgoing tile for SETTLE_CYCLES, then holds the incoming tile in reset for
// RST_CYCLES before handing it the bus.
//   clk, rst     : clock, synchronous active-high reset
//   sel_req      : requested tile (async pin, synchronized here)
//   ui_in        : shared input bus, routed to the running tile only
//   tile_uo      : packed tile outputs, tile i at [8i+7:8i]
//   tile_ui      : packed per-tile inputs, same packing
//   tile_ena     : per-tile clock enable (at most one set)
//   tile_rst_n   : per-tile active-low reset
//   uo_out       : output of the running tile, 0 otherwise
//   active_sel   : tile currently owned
//   busy         : high outside RUN
//   switch_count : completed switches, saturating
module microtile_sequencer
  import microtile_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int RST_CYCLES    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEL_W-1:0]            sel_req,
  input  logic [TILE_W-1:0]           ui_in,
  input  logic [NUM_TILES*TILE_W-1:0] tile_uo,
  output logic [NUM_TILES*TILE_W-1:0] tile_ui,
  output logic [NUM_TILES-1:0]        tile_ena,
  output logic [NUM_TILES-1:0]        tile_rst_n,
  output logic [TILE_W-1:0]           uo_out,
  output logic [SEL_W-1:0]            active_sel,
  output logic                        busy,
  output logic [7:0]                  switch_count
);

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_INIT    = CNT_W'(RST_CYCLES - 1);

  tile_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] target, target_nx, active_nx;
  logic [SEL_W-1:0] sel_s;
  logic [7:0]       count_nx;

  sync2 #(.W(SEL_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sel_req),
    .q   (sel_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RESET;
      cnt          <= RST_INIT;
      active_sel   <= '0;
      target       <= '0;
      switch_count <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      active_sel   <= active_nx;
      target       <= target_nx;
      switch_count <= count_nx;
    end
  end

  // sel_s is only looked at in RUN, so requests arriving mid-switch wait
  // until the new tile has run for at least one cycle.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    active_nx = active_sel;
    target_nx = target;
    count_nx  = switch_count;
    unique case (state)
      ST_RESET: begin
        if (cnt == '0) state_nx = ST_RUN;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      ST_RUN: begin
        if (sel_s != active_sel) begin
          target_nx = sel_s;
          cnt_nx    = SETTLE_INIT;
          state_nx  = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        if (cnt == '0) begin
          // Moving ownership drops the old tile's rst_n via the output logic.
          active_nx = target;
          cnt_nx    = RST_INIT;
          state_nx  = ST_RESET;
          if (switch_count != 8'hFF) count_nx = switch_count + 8'd1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = ST_RESET;
    endcase
  end

  logic [NUM_TILES-1:0][TILE_W-1:0] uo_v, ui_v;
  logic                             run;

  assign uo_v = tile_uo;
  assign run  = (state == ST_RUN);

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_tile
    logic own;
    assign own           = (active_sel == SEL_W'(g));
    assign tile_ena[g]   = own && (state != ST_QUIESCE);
    assign tile_rst_n[g] = own && (state != ST_RESET);
    assign ui_v[g]       = (own && run) ? ui_in : '0;
  end

  assign tile_ui = ui_v;
  assign uo_out  = run ? uo_v[active_sel] : '0;
  assign busy    = !run;

endmodule

// File: tb/tb_microtile_sequencer.sv
module tb_microtile_sequencer;

  localparam int SETTLE = 2;
  localparam int RSTC   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel_req;
  logic [7:0]  ui_in;
  logic [31:0] tile_uo;
  logic [31:0] tile_ui;
  logic [3:0]  tile_ena, tile_rst_n;
  logic [7:0]  uo_out;
  logic [1:0]  active_sel;
  logic        busy;
  logic [7:0]  switch_count;

  microtile_sequencer #(.SETTLE_CYCLES(SETTLE), .RST_CYCLES(RSTC)) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_req      (sel_req),
    .ui_in        (ui_in),
    .tile_uo      (tile_uo),
    .tile_ui      (tile_ui),
    .tile_ena     (tile_ena),
    .tile_rst_n   (tile_rst_n),
    .uo_out       (uo_out),
    .active_sel   (active_sel),
    .busy         (busy),
    .switch_count (switch_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Tile data buses change shortly after each edge so they are stable at
  // the sampling negedge.
  initial begin
    ui_in = 8'h00; tile_uo = 32'h0;
  end
  always @(posedge clk) begin
    #1;
    ui_in   = 8'($urandom);
    tile_uo = $urandom;
  end

  // Timeline model: every cycle is classified by how many edges have passed
  // since the current episode (a reset, or a switch decision) began.
  int         n = 0;
  int         ep_start = 0;
  bit         ep_switch = 0;
  bit         m_valid = 0;
  logic [1:0] m_old = 0, m_new = 0, m_s1 = 0, m_s2 = 0;
  int         m_count = 0;

  // 0 = frozen outgoing tile, 1 = incoming tile in reset, 2 = running
  function automatic int phase(input int at);
    int d;
    d = at - ep_start;
    if (ep_switch) begin
      if (d < SETTLE) return 0;
      if (d < SETTLE + RSTC) return 1;
      return 2;
    end
    return (d < RSTC) ? 1 : 2;
  endfunction

  always @(posedge clk) begin
    n = n + 1;
    if (rst) begin
      m_valid = 1; ep_start = n; ep_switch = 0;
      m_old = 0; m_new = 0; m_count = 0; m_s1 = 0; m_s2 = 0;
    end else if (m_valid) begin
      if (phase(n - 1) == 2 && m_s2 != m_new) begin
        ep_start = n; ep_switch = 1; m_old = m_new; m_new = m_s2;
      end else if (ep_switch && (n - ep_start) == SETTLE && m_count < 255) begin
        m_count++;
      end
      m_s2 = m_s1;
      m_s1 = sel_req;
    end
  end

  bit saw_t3 = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      int         ph;
      logic [1:0] own;
      logic [3:0] oh;
      ph  = phase(n);
      own = (ep_switch && ph == 0) ? m_old : m_new;
      oh  = 4'b0001 << own;
      chk("ena",    32'(tile_ena),     32'(ph == 0 ? 4'b0 : oh));
      chk("rst_n",  32'(tile_rst_n),   32'(ph == 1 ? 4'b0 : oh));
      chk("ui",     tile_ui,           ph == 2 ? (32'(ui_in) << (8 * own)) : 32'h0);
      chk("uo",     32'(uo_out),       ph == 2 ? 32'((tile_uo >> (8 * own)) & 32'hFF) : 32'h0);
      chk("busy",   32'(busy),         32'(ph != 2));
      chk("active", 32'(active_sel),   32'(own));
      chk("count",  32'(switch_count), 32'(m_count));
      chk("onehot", 32'($countones(tile_ena) <= 1), 32'h1);
      if (tile_ena[3]) saw_t3 = 1;
    end
  end

  task automatic wait_busy(input logic lvl, input string nm);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy === lvl) break;
    end
    chk(nm, 32'(busy), 32'(lvl));
  endtask

  task automatic switch_to(input logic [1:0] t);
    sel_req = t;
    wait_busy(1'b1, "sw_start");
    wait_busy(1'b0, "sw_done");
    chk("sw_active", 32'(active_sel), 32'(t));
  endtask

  initial begin
    logic [7:0] c0;
    rst = 1'b1; sel_req = 2'd0;
    repeat (3) @(negedge clk);

    // Power-up: busy for exactly RST_CYCLES cycles after release.
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("por_busy", 32'(busy), 32'h1);
    end
    @(negedge clk);
    chk("por_busy_lo", 32'(busy),       32'h0);
    chk("por_rst_n",   32'(tile_rst_n), 32'h1);
    chk("por_ena",     32'(tile_ena),   32'h1);
    chk("por_uo",      32'(uo_out),     32'(tile_uo[7:0]));

    // Request equal to active tile: nothing happens.
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("same_busy",  32'(busy),         32'h0);
      chk("same_count", 32'(switch_count), 32'h0);
    end

    // 0 -> 2: busy after 3 edges, RUN on tile 2 after 9 edges.
    sel_req = 2'd2;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("lat_busy", 32'(busy), 32'(k >= 3 && k <= 8));
    end
    chk("lat_count",  32'(switch_count),  32'h1);
    chk("lat_active", 32'(active_sel),    32'h2);
    chk("lat_uo",     32'(uo_out),        32'(tile_uo[23:16]));
    chk("lat_t0",     32'({tile_ena[0], tile_rst_n[0]}), 32'h0);

    // Retargeting during QUIESCE: finish on 2, run one cycle, then go to 1.
    switch_to(2'd0);
    saw_t3 = 0;
    sel_req = 2'd2;
    wait_busy(1'b1, "tog_start");
    sel_req = 2'd3;
    @(negedge clk);
    sel_req = 2'd1;
    wait_busy(1'b0, "tog_run2");
    chk("tog_active2", 32'(active_sel), 32'h2);
    @(negedge clk);
    chk("tog_rerun", 32'(busy), 32'h1);
    wait_busy(1'b0, "tog_run1");
    chk("tog_active1", 32'(active_sel),   32'h1);
    chk("tog_count",   32'(switch_count), 32'h4);
    chk("tog_no_t3",   32'(saw_t3),       32'h0);

    // Reset in the second QUIESCE cycle of 0 -> 3.
    switch_to(2'd0);
    sel_req = 2'd3;
    wait_busy(1'b1, "abort_start");
    @(negedge clk);
    rst = 1'b1; sel_req = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_active", 32'(active_sel),   32'h0);
    chk("abort_count",  32'(switch_count), 32'h0);
    chk("abort_ena",    32'(tile_ena),     32'h1);
    chk("abort_rst_n",  32'(tile_rst_n),   32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'h1);
    end
    @(negedge clk);
    chk("abort_run", 32'(busy), 32'h0);

    // 260 alternating switches: counter saturates.
    for (int i = 0; i < 260; i++) begin
      c0 = switch_count;
      switch_to((i % 2 == 0) ? 2'd1 : 2'd0);
      if (i == 0) chk("sat_first", 32'(switch_count), 32'(c0 + 8'd1));
    end
    chk("sat_count", 32'(switch_count), 32'd255);
    repeat (5) @(negedge clk);
    chk("sat_hold", 32'(switch_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
